// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and widths for the register-file writeback arbiter slice.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR  = 5;
    localparam int REG_WIDTH = 32;

    // One writeback requester's payload: destination register and value.
    typedef struct packed {
        logic [REG_ADDR-1:0]  addr;
        logic [REG_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the writeback request side and the register-file write port.
// The master modport is the execution-unit/testbench side, the slave
// modport is the arbiter.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
);

    localparam int IDW = $clog2(NUM_REQ);

    logic                 i_hold;
    logic [NUM_REQ-1:0]   i_req_valid;
    wb_req_t              i_req [NUM_REQ];
    logic [NUM_REQ-1:0]   o_req_ready;
    logic                 o_write_enable;
    logic [REG_ADDR-1:0]  o_write_select;
    logic [REG_WIDTH-1:0] o_write_data;
    logic [IDW-1:0]       o_grant_id;

    modport master (
        output i_hold, i_req_valid, i_req,
        input  o_req_ready, o_write_enable, o_write_select, o_write_data, o_grant_id
    );

    modport slave (
        input  i_hold, i_req_valid, i_req,
        output o_req_ready, o_write_enable, o_write_select, o_write_data, o_grant_id
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Pure combinational round-robin picker: scans valid starting at ptr,
// wrapping modulo N, and returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         valid_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int IW = $clog2(N);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // First valid requester at or after ptr (circularly) wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (!any_o && valid_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// NUM_REQ writeback requesters. The winner is accepted with a combinational
// ready pulse and its write is registered onto the port one cycle later.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int REG_ADDR  = regfile_wb_arbiter_pkg::REG_ADDR,
    parameter int REG_WIDTH = regfile_wb_arbiter_pkg::REG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDW-1:0]       pick_idx;
    logic                 pick_any;
    logic                 fire;

    logic [IDW-1:0]       ptr_q,  ptr_d;
    logic                 we_q,   we_d;
    logic [REG_ADDR-1:0]  sel_q,  sel_d;
    logic [REG_WIDTH-1:0] data_q, data_d;
    logic [IDW-1:0]       gid_q,  gid_d;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .valid_i (bus.i_req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // A grant happens only when someone is valid and we are neither held nor in reset.
    assign fire            = pick_any & ~bus.i_hold & ~rst;
    assign bus.o_req_ready = fire ? pick_grant : '0;

    // Next state: capture the winner and advance the pointer past it, else drop enable and hold.
    always_comb begin
        ptr_d  = ptr_q;
        we_d   = 1'b0;
        sel_d  = sel_q;
        data_d = data_q;
        gid_d  = gid_q;
        if (fire) begin
            we_d   = 1'b1;
            sel_d  = bus.i_req[pick_idx].addr;
            data_d = bus.i_req[pick_idx].data;
            gid_d  = pick_idx;
            ptr_d  = (pick_idx == IDW'(NUM_REQ-1)) ? '0 : pick_idx + IDW'(1);
        end
    end

    // Output register and priority pointer; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
            gid_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            sel_q  <= sel_d;
            data_q <= data_d;
            gid_q  <= gid_d;
        end
    end

    assign bus.o_write_enable = we_q;
    assign bus.o_write_select = sel_q;
    assign bus.o_write_data   = data_q;
    assign bus.o_grant_id     = gid_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by a random
// phase, all checked against a round-robin reference model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(N)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // stimulus state
    logic [N-1:0]         v;
    logic [REG_ADDR-1:0]  a [N];
    logic [REG_WIDTH-1:0] d [N];
    logic                 hold;
    bit                   consume;

    // reference model state
    int                   mptr;
    logic                 m_we;
    logic [REG_ADDR-1:0]  m_sel;
    logic [REG_WIDTH-1:0] m_dat;
    int                   m_id;
    int                   last_win;
    logic [REG_WIDTH-1:0] m_rf [32];
    bit                   m_wr [32];
    int                   wait_c [N];

    // register file fed by the DUT's write port
    logic [REG_WIDTH-1:0] dut_rf [32];
    always @(posedge clk) begin
        if (bus.o_write_enable === 1'b1) dut_rf[bus.o_write_select] <= bus.o_write_data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus.i_hold      = hold;
        bus.i_req_valid = v;
        for (int i = 0; i < N; i++) begin
            bus.i_req[i].addr = a[i];
            bus.i_req[i].data = d[i];
        end
    endtask

    // One clock: drive, check ready, step the model across the edge, check the port.
    task automatic cycle();
        int win;
        logic [N-1:0] er;
        apply();
        #1;
        win = -1;
        if (!hold && !rst) begin
            for (int k = 0; k < N; k++) begin
                int c = (mptr + k) % N;
                if (win < 0 && v[c]) win = c;
            end
        end
        er = '0;
        if (win >= 0) er[win] = 1'b1;
        check("ready", 64'(bus.o_req_ready), 64'(er));
        if (rst) begin
            m_we = 1'b0; m_sel = '0; m_dat = '0; m_id = 0; mptr = 0;
            check("rst_we",  64'(bus.o_write_enable), 64'(0));
            check("rst_sel", 64'(bus.o_write_select), 64'(0));
            check("rst_dat", 64'(bus.o_write_data),   64'(0));
            check("rst_gid", 64'(bus.o_grant_id),     64'(0));
        end
        @(posedge clk);
        #1;
        if (m_we) begin
            m_rf[m_sel] = m_dat;
            m_wr[m_sel] = 1'b1;
        end
        if (rst) begin
            m_we = 1'b0; m_sel = '0; m_dat = '0; m_id = 0; mptr = 0;
        end else if (win >= 0) begin
            m_we  = 1'b1;
            m_sel = a[win];
            m_dat = d[win];
            m_id  = win;
            mptr  = (win + 1) % N;
            if (consume) v[win] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        last_win = win;
        check("we",  64'(bus.o_write_enable), 64'(m_we));
        check("sel", 64'(bus.o_write_select), 64'(m_sel));
        check("dat", 64'(bus.o_write_data),   64'(m_dat));
        check("gid", 64'(bus.o_grant_id),     64'(m_id));
        @(negedge clk);
    endtask

    initial begin
        int exp3 [6];
        logic [N-1:0] vb;

        rst = 1'b1; hold = 1'b0; v = '0; consume = 1'b0;
        for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; wait_c[i] = 0; end
        for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_wr[i] = 1'b0; end
        m_we = 1'b0; m_sel = '0; m_dat = '0; m_id = 0; mptr = 0; last_win = -1;
        @(negedge clk);
        cycle();
        cycle();

        // Reset mid-stream with req0 valid
        rst = 1'b0;
        v = 3'b001; a[0] = 5'd7; d[0] = 32'h0000_1234;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("post_rst_win", 64'(last_win), 64'(0));

        // Single request from req1
        v = 3'b010; a[1] = 5'd5; d[1] = 32'hDEAD_BEEF;
        cycle();
        check("single_we",  64'(bus.o_write_enable), 64'(1));
        check("single_sel", 64'(bus.o_write_select), 64'(5));
        check("single_dat", 64'(bus.o_write_data),   64'hDEAD_BEEF);
        check("single_gid", 64'(bus.o_grant_id),     64'(1));
        v = '0;
        cycle();
        check("single_idle_we", 64'(bus.o_write_enable), 64'(0));

        // Wrap and skip from ptr=2 with req0 and req1 valid
        v = 3'b011; a[0] = 5'd1; d[0] = 32'hA0; a[1] = 5'd2; d[1] = 32'hA1;
        cycle(); check("wrap0", 64'(last_win), 64'(0));
        cycle(); check("wrap1", 64'(last_win), 64'(1));
        cycle(); check("wrap2", 64'(last_win), 64'(0));

        // Contention from ptr=0
        v = '0; rst = 1'b1; cycle(); rst = 1'b0;
        exp3 = '{0, 1, 2, 0, 1, 2};
        v = 3'b111;
        for (int i = 0; i < N; i++) begin a[i] = 5'(10 + i); d[i] = 32'(32'hC0 + i); end
        for (int s = 0; s < 6; s++) begin
            cycle();
            check("cont_order", 64'(last_win), 64'(exp3[s]));
            check("cont_we", 64'(bus.o_write_enable), 64'(1));
        end

        // Same destination from req0 and req2
        v = 3'b101; a[0] = 5'd3; d[0] = 32'h11; a[2] = 5'd3; d[2] = 32'h22;
        cycle();
        check("same_first", 64'(bus.o_write_data), 64'h11);
        v = 3'b100;
        cycle();
        check("same_second", 64'(bus.o_write_data), 64'h22);
        v = '0;
        cycle();
        cycle();
        check("same_rf", 64'(dut_rf[3]), 64'h22);

        // Hold with all requesters valid
        v = 3'b111; hold = 1'b1;
        for (int s = 0; s < 3; s++) begin
            cycle();
            check("hold_nogrant", 64'(last_win), 64'hFFFF_FFFF_FFFF_FFFF);
            check("hold_we", 64'(bus.o_write_enable), 64'(0));
        end
        hold = 1'b0;
        cycle(); check("resume0", 64'(last_win), 64'(0));
        cycle(); check("resume1", 64'(last_win), 64'(1));
        cycle(); check("resume2", 64'(last_win), 64'(2));

        // Random traffic with requests held until accepted
        v = '0; consume = 1'b1;
        for (int i = 0; i < N; i++) wait_c[i] = 0;
        for (int s = 0; s < 400; s++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && ($urandom % 2 == 0)) begin
                    v[i] = 1'b1;
                    a[i] = 5'($urandom);
                    d[i] = $urandom;
                end
            end
            hold = ($urandom % 8 == 0);
            vb = v;
            cycle();
            for (int i = 0; i < N; i++) begin
                if (vb[i] && !hold) begin
                    if (last_win == i) begin
                        check("fair", 64'(wait_c[i] < N), 64'(1));
                        wait_c[i] = 0;
                    end else begin
                        wait_c[i]++;
                    end
                end
            end
        end
        v = '0; hold = 1'b0;
        cycle();
        cycle();
        for (int i = 0; i < 32; i++) begin
            if (m_wr[i]) check("rf_final", 64'(dut_rf[i]), 64'(m_rf[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Round-robin arbiter that shares the register file's single write port between several writeback requesters (e.g. ALU, load unit, multiplier). Each requester presents valid/address/data and is accepted with a one-cycle ready pulse. The winning request is captured into an output register that drives the register file write port one cycle later. The block sits between the execution units and the register file write inputs.

## Interface
Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- REG_ADDR, const_pkg::REG_ADDR, register select width.
- REG_WIDTH, const_pkg::REG_WIDTH, register data width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- i_hold  input  1  freeze: no new grants while high.
- i_req_valid  input  NUM_REQ  per-requester write request.
- i_req_addr  input  NUM_REQ x REG_ADDR  per-requester destination register.
- i_req_data  input  NUM_REQ x REG_WIDTH  per-requester write data.
- o_req_ready  output  NUM_REQ  one-hot grant; request consumed when valid & ready.
- o_write_enable  output  1  to register file write enable.
- o_write_select  output  REG_ADDR  to register file write select.
- o_write_data  output  REG_WIDTH  to register file write data.
- o_grant_id  output  $clog2(NUM_REQ)  index of requester whose write is on the port.

## Operation
- Priority pointer ptr (range 0..NUM_REQ-1, reset 0). Search order: ptr, ptr+1, … wrapping modulo NUM_REQ. The first valid requester wins.
- o_req_ready is combinational and at most one-hot. It is asserted only for the winner, only when i_hold=0 and rst=0. Ready may depend on valid.
- On a grant at edge t:
  - The output register captures {1, addr, data, id}.
  - ptr ← (winner+1) mod NUM_REQ; wraps from NUM_REQ-1 to 0.
- Otherwise:
  - o_write_enable ← 0.
  - o_write_select, o_write_data and o_grant_id hold their previous values.
  - ptr is unchanged.
- Requesters must hold valid/addr/data stable until accepted; the arbiter never drops a valid request.
- Same destination address from two requesters in one cycle: the requests are serialised in grant order. The later grant's data is what finally remains in the register.
- i_hold=1: all ready low, o_write_enable low from the next edge, ptr frozen. Arbitration resumes on the first cycle hold is low.
- No special handling of register 0; the write is forwarded as-is.
- Reset (any time, including mid-grant):
  - o_write_enable=0, o_write_select=0, o_write_data=0, o_grant_id=0, ptr=0.
  - o_req_ready=0 while rst is high.
  - A grant in the reset cycle is discarded.

## Timing
- Accept to register file write enable: 1 cycle; data is in the register file after the following edge (2 edges after accept).
- Throughput: one write per cycle sustained, any requester mix.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles, absent hold.
- Single requester alone: granted every cycle it is valid.
- No combinational path from i_req_* to o_write_*; all write-port outputs come from flops.

## Structure
- Per-requester request bundle struct {addr, data} belongs in const_pkg; the arbiter ports use an unpacked array of it.
- Natural sub-module: rr_arbiter. It is a pure round-robin picker taking valid vector and ptr, and returning a one-hot grant and index. It is reusable for other shared resources.
- Top level holds ptr, the output register and the hold gating.

## Test plan
- Reset: assert rst mid-stream with req0 valid.
  - All outputs 0 and ready 0 during rst.
  - First grant after release goes to req0 (ptr=0).
- Single request: req1 valid, addr=5, data=0xDEADBEEF at cycle 0.
  - ready1=1 at cycle 0.
  - Cycle 1: enable=1, select=5, data=0xDEADBEEF, grant_id=1.
  - Cycle 2: enable=0.
- Contention: all three valid continuously for 6 cycles from ptr=0.
  - Grant order 0,1,2,0,1,2.
  - Enable stays high cycles 1–6.
- Wrap and skip: ptr=2, only req0 and req1 valid.
  - Grant req0, then req1, then req0.
- Same address: req0 addr=3 data=0x11 and req2 addr=3 data=0x22 together, ptr=0.
  - Writes occur in two consecutive cycles, 0x11 then 0x22.
  - Register file holds 0x22 afterwards.
- Hold: all valid, i_hold=1 for 3 cycles.
  - Ready all 0 and enable 0 from the next edge; ptr unchanged.
  - Release resumes at the same ptr with no request lost.
